reg_muldiv_unit: RTL and testbench

Iterative 64-bit multiply/divide unit sitting directly upstream of the register bank write port. It accepts operands and a destination register number, computes over a fixed 64-iteration sequence, then presents a one-cycle write request (register number, data, write strobe) that the writeback path forwards to the register bank's write inputs. Operands come from the register bank read ports, so the unit stalls the front end via `oBusy` while it runs.

---
 rtl/reg_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_reg_muldiv_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_muldiv_unit.sv
// Iterative 64-bit multiply/divide unit feeding the register bank write port.
// One shift-add or restoring-divide step per cycle over 64 cycles, then a one-cycle write request.
module reg_muldiv_unit #(
   parameter int ITER = 64
) (
   input  logic        iCLK,
   input  logic        iCLR,
   input  logic        iStart,
   input  logic [1:0]  iOp,
   input  logic [63:0] iOperandA,
   input  logic [63:0] iOperandB,
   input  logic [4:0]  iDestReg,
   output logic        oBusy,
   output logic        oDone,
   output logic        oRegWrite,
   output logic [4:0]  oWriteRegister,
   output logic [63:0] oWriteData
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_UMULH = 2'b01;
   localparam logic [1:0] OP_UDIV  = 2'b10;
   localparam logic [1:0] OP_SDIV  = 2'b11;
   localparam logic [6:0] LAST_CNT = 7'(ITER - 1);

   state_t        state;
   state_t        state_nxt;
   logic [6:0]    cnt;
   logic [1:0]    op_q;
   logic [4:0]    dest_q;
   logic [63:0]   opb_q;      // multiplier, or divisor magnitude
   logic [127:0]  work_q;     // {acc_hi, multiplier-shift} for MUL, quotient/dividend in [63:0] for DIV
   logic [64:0]   rem_q;
   logic          neg_q;
   logic          div_zero_q;
   logic          done_q;
   logic          reg_write_q;
   logic [4:0]    wreg_q;
   logic [63:0]   wdata_q;

   logic [64:0]   mul_sum;
   logic [127:0]  mul_next;
   logic [65:0]   rem_shift;
   logic          rem_ge;
   logic [64:0]   rem_next;
   logic [63:0]   quo_next;
   logic [127:0]  work_next;
   logic [63:0]   result;
   logic [63:0]   mag_a;
   logic [63:0]   mag_b;
   logic          last_iter;

   assign last_iter = (cnt == LAST_CNT);

   // ---------------- state register ----------------
   always_ff @(posedge iCLK) begin
      if (iCLR) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (iStart) state_nxt = S_RUN;
         S_RUN:   if (last_iter) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- one iteration of the datapath ----------------
   always_comb begin
      mag_a = iOperandA;
      mag_b = iOperandB;
      if (iOp == OP_SDIV) begin
         if (iOperandA[63]) mag_a = -iOperandA;
         if (iOperandB[63]) mag_b = -iOperandB;
      end
   end

   always_comb begin
      mul_sum   = {1'b0, work_q[127:64]} + (work_q[0] ? {1'b0, opb_q} : 65'd0);
      mul_next  = {mul_sum, work_q[63:1]};
      rem_shift = {rem_q, work_q[63]};
      rem_ge    = (rem_shift >= {2'b00, opb_q});
      rem_next  = rem_ge ? 65'(rem_shift - {2'b00, opb_q}) : 65'(rem_shift);
      quo_next  = {work_q[62:0], rem_ge};
      work_next = op_q[1] ? {64'd0, quo_next} : mul_next;
   end

   // Magnitudes of 0x8000.. / -1 give 2^63, whose negation wraps back to 0x8000..
   always_comb begin
      result = 64'd0;
      case (op_q)
         OP_MUL:   result = mul_next[63:0];
         OP_UMULH: result = mul_next[127:64];
         OP_UDIV:  result = div_zero_q ? 64'd0 : quo_next;
         OP_SDIV:  result = div_zero_q ? 64'd0 : (neg_q ? -quo_next : quo_next);
         default:  result = 64'd0;
      endcase
   end

   // ---------------- operand latch, iteration and writeback registers ----------------
   always_ff @(posedge iCLK) begin
      if (iCLR) begin
         cnt         <= 7'd0;
         op_q        <= 2'd0;
         dest_q      <= 5'd0;
         opb_q       <= 64'd0;
         work_q      <= 128'd0;
         rem_q       <= 65'd0;
         neg_q       <= 1'b0;
         div_zero_q  <= 1'b0;
         done_q      <= 1'b0;
         reg_write_q <= 1'b0;
         wreg_q      <= 5'd0;
         wdata_q     <= 64'd0;
      end else begin
         done_q      <= 1'b0;
         reg_write_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (iStart) begin
                  cnt        <= 7'd0;
                  op_q       <= iOp;
                  dest_q     <= iDestReg;
                  opb_q      <= mag_b;
                  work_q     <= {64'd0, mag_a};
                  rem_q      <= 65'd0;
                  neg_q      <= (iOp == OP_SDIV) && (iOperandA[63] ^ iOperandB[63]);
                  div_zero_q <= (iOperandB == 64'd0);
               end
            end
            S_RUN: begin
               work_q <= work_next;
               rem_q  <= rem_next;
               if (last_iter) begin
                  cnt         <= 7'd0;
                  done_q      <= 1'b1;
                  reg_write_q <= (dest_q != 5'd31);
                  wreg_q      <= dest_q;
                  wdata_q     <= result;
               end else begin
                  cnt <= cnt + 7'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign oBusy          = (state != S_IDLE);
   assign oDone          = done_q;
   assign oRegWrite      = reg_write_q;
   assign oWriteRegister = wreg_q;
   assign oWriteData     = wdata_q;

endmodule

// File: tb/tb_reg_muldiv_unit.sv
// Bench for reg_muldiv_unit: arithmetic reference model with a per-cycle compare,
// plus directed vectors carrying hand-computed results.
module tb_reg_muldiv_unit;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        iCLR;
   logic        iStart;
   logic [1:0]  iOp;
   logic [63:0] iOperandA;
   logic [63:0] iOperandB;
   logic [4:0]  iDestReg;
   logic        oBusy;
   logic        oDone;
   logic        oRegWrite;
   logic [4:0]  oWriteRegister;
   logic [63:0] oWriteData;

   always #5 clk = ~clk;

   reg_muldiv_unit #(.ITER(64)) dut (
      .iCLK           (clk),
      .iCLR           (iCLR),
      .iStart         (iStart),
      .iOp            (iOp),
      .iOperandA      (iOperandA),
      .iOperandB      (iOperandB),
      .iDestReg       (iDestReg),
      .oBusy          (oBusy),
      .oDone          (oDone),
      .oRegWrite      (oRegWrite),
      .oWriteRegister (oWriteRegister),
      .oWriteData     (oWriteData)
   );

   int checks = 0;
   int errors = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endfunction

   // ---------------- reference arithmetic ----------------
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      logic [63:0]  ma, mb, q;
      p = {64'd0, a} * {64'd0, b};
      case (op)
         2'b00: return p[63:0];
         2'b01: return p[127:64];
         2'b10: return (b == 64'd0) ? 64'd0 : a / b;
         default: begin
            if (b == 64'd0) return 64'd0;
            if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return a;
            ma = a[63] ? -a : a;
            mb = b[63] ? -b : b;
            q  = ma / mb;
            return (a[63] ^ b[63]) ? -q : q;
         end
      endcase
   endfunction

   // ---------------- scoreboard / model ----------------
   // m_rem counts edges left until idle: 65 right after accept, 1 during the done cycle.
   logic [68:0] exp_q[$];
   int          m_rem   = 0;
   logic        m_valid = 1'b0;
   logic [4:0]  m_wreg  = 5'd0;
   logic [63:0] m_wdata = 64'd0;

   always @(posedge clk) begin
      if (iCLR) begin
         m_rem   = 0;
         m_wreg  = 5'd0;
         m_wdata = 64'd0;
         exp_q.delete();
         m_valid = 1'b1;
      end else if (m_rem == 0) begin
         if (iStart) begin
            exp_q.push_back({iDestReg, ref_result(iOp, iOperandA, iOperandB)});
            m_rem = 65;
         end
      end else begin
         m_rem--;
         if (m_rem == 1 && exp_q.size() > 0) {m_wreg, m_wdata} = exp_q.pop_front();
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("busy",           64'(oBusy),          64'(m_rem > 0));
         check("done",           64'(oDone),          64'(m_rem == 1));
         check("reg_write",      64'(oRegWrite),      64'(m_rem == 1 && m_wreg != 5'd31));
         check("write_register", 64'(oWriteRegister), 64'(m_wreg));
         check("write_data",     oWriteData,          m_wdata);
      end
   end

   // ---------------- driver tasks ----------------
   // Call just after a rising edge with the unit idle; returns just after the edge that ends DONE.
   task automatic run_op(input string name, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] dest, input logic [63:0] exp);
      int   cyc;
      logic seen;
      iStart = 1'b1; iOp = op; iOperandA = a; iOperandB = b; iDestReg = dest;
      @(posedge clk); #1;
      iStart = 1'b0;
      iOperandA = {$urandom, $urandom};
      iOperandB = {$urandom, $urandom};
      iDestReg  = 5'($urandom_range(0, 31));
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (oDone) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no done pulse within %0d cycles", name, cyc);
      end else begin
         check({name, "_latency"},   64'(cyc),            64'd65);
         check({name, "_data"},      oWriteData,          exp);
         check({name, "_reg"},       64'(oWriteRegister), 64'(dest));
         check({name, "_reg_write"}, 64'(oRegWrite),      64'(dest != 5'd31));
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input string name);
      int cyc;
      cyc = 0;
      while (oBusy && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (oBusy) begin
         checks++;
         errors++;
         $display("FAIL %s_idle_timeout: busy=%b after %0d cycles", name, oBusy, cyc);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      iCLR = 1'b1; iStart = 1'b0; iOp = 2'b00;
      iOperandA = 64'd0; iOperandB = 64'd0; iDestReg = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",  64'(oBusy),      64'd0);
      check("reset_data",  oWriteData,      64'd0);
      iCLR = 1'b0;

      run_op("mul_ff_x2",   2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op("umulh_ff_x2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'h1);
      run_op("umulh_ff_ff", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,
             64'hFFFF_FFFF_FFFF_FFFE);
      run_op("udiv_100_7",  2'b10, 64'd100, 64'd7, 5'd7, 64'd14);
      run_op("sdiv_m100_7", 2'b11, -64'd100, 64'd7, 5'd8, 64'hFFFF_FFFF_FFFF_FFF2);
      run_op("sdiv_100_m7", 2'b11, 64'd100, -64'd7, 5'd9, 64'hFFFF_FFFF_FFFF_FFF2);
      run_op("sdiv_m100_m7", 2'b11, -64'd100, -64'd7, 5'd10, 64'd14);
      run_op("udiv_5_0",    2'b10, 64'd5, 64'd0, 5'd11, 64'd0);
      run_op("sdiv_min_m1", 2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
             64'h8000_0000_0000_0000);
      run_op("mul_dest31",  2'b00, 64'd3, 64'd4, 5'd31, 64'd12);
      run_op("udiv_big",    2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 5'd1, 64'hFFFF_FFFF);

      // Reset mid-run: clear lands on E30, restart is accepted at E32.
      iStart = 1'b1; iOp = 2'b00; iOperandA = 64'd123; iOperandB = 64'd456; iDestReg = 5'd9;
      @(posedge clk); #1;
      iStart = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      iCLR = 1'b1;
      @(posedge clk); #1;
      iCLR = 1'b0;
      check("midreset_busy",      64'(oBusy),          64'd0);
      check("midreset_done",      64'(oDone),          64'd0);
      check("midreset_reg_write", 64'(oRegWrite),      64'd0);
      check("midreset_reg",       64'(oWriteRegister), 64'd0);
      check("midreset_data",      oWriteData,          64'd0);
      @(posedge clk); #1;
      run_op("after_reset_mul", 2'b00, 64'd5, 64'd7, 5'd9, 64'd35);

      // Clear wins over a simultaneous start.
      iCLR = 1'b1; iStart = 1'b1;
      @(posedge clk); #1;
      iCLR = 1'b0; iStart = 1'b0;
      check("clr_over_start_busy", 64'(oBusy), 64'd0);
      @(posedge clk); #1;

      // Start held high for 70 edges with operands changing every cycle.
      iStart = 1'b1; iOp = 2'b00; iOperandA = 64'd7; iOperandB = 64'd6; iDestReg = 5'd3;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk); #1;
         if (i == 64) begin
            check("hold_done",      64'(oDone),          64'd1);
            check("hold_data",      oWriteData,          64'd42);
            check("hold_reg",       64'(oWriteRegister), 64'd3);
            check("hold_reg_write", 64'(oRegWrite),      64'd1);
         end
         if (i == 65) check("hold_idle_e65", 64'(oBusy), 64'd0);
         if (i == 66) check("hold_busy_e66", 64'(oBusy), 64'd1);
         iOperandA = {$urandom, $urandom};
         iOperandB = 64'($urandom_range(1, 1000));
         iDestReg  = 5'($urandom_range(0, 30));
      end
      iStart = 1'b0;
      wait_idle("hold_second");
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
